// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the Tomasulo reorder buffer.
// The result value lives in a separate array so its width can follow the module's DATA_W.
package tomasulo_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;
    localparam int DATA_W    = 16;
    localparam int FUNC_W    = 4;
    localparam int RD_W      = 4;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] FN_MUL = 4'b0010;
    localparam logic [FUNC_W-1:0] FN_DIV = 4'b0011;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [FUNC_W-1:0] func;
        logic [RD_W-1:0]   rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, out-of-order CDB completion, in-order single commit.
// Flush outranks alloc/cdb/commit; lookups bypass the CDB combinationally.
module rob_commit
    import tomasulo_pkg::*;
#(
    parameter int ROB_DEPTH = tomasulo_pkg::ROB_DEPTH,
    parameter int DATA_W    = tomasulo_pkg::DATA_W
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [RD_W-1:0]   alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [TAG_W-1:0]  lk1_tag,
    input  logic [TAG_W-1:0]  lk2_tag,
    output logic              lk1_ready,
    output logic              lk2_ready,
    output logic [DATA_W-1:0] lk1_value,
    output logic [DATA_W-1:0] lk2_value,
    input  logic              flush,
    output logic              commit_valid,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [RD_W-1:0]   commit_rd,
    output logic [FUNC_W-1:0] commit_func,
    output logic [DATA_W-1:0] commit_value,
    output logic              full,
    output logic              empty,
    output logic [TAG_W:0]    count
);

    localparam int CNT_W = TAG_W + 1;

    rob_entry_t        ent [ROB_DEPTH];
    logic [DATA_W-1:0] val [ROB_DEPTH];
    logic [TAG_W-1:0]  head, tail;
    logic              alloc_ok, commit_ok, cdb_ok;

    assign full        = (count == CNT_W'(ROB_DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail;
    assign alloc_ok    = alloc_valid && !full;
    assign commit_ok   = !empty && ent[head].busy && ent[head].ready;
    // A tail entry being allocated this edge is not busy yet, so its CDB write drops here.
    assign cdb_ok      = cdb_valid && ent[cdb_tag].busy;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_func  <= '0;
            commit_value <= '0;
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
        end else begin
            commit_valid <= commit_ok;
            if (cdb_ok) ent[cdb_tag].ready <= 1'b1;
            if (alloc_ok) begin
                ent[tail] <= '{busy: 1'b1, ready: 1'b0, func: alloc_func, rd: alloc_rd};
                tail      <= tail + 1'b1;
            end
            if (commit_ok) begin
                commit_tag       <= head;
                commit_rd        <= ent[head].rd;
                commit_func      <= ent[head].func;
                commit_value     <= val[head];
                ent[head].busy   <= 1'b0;
                ent[head].ready  <= 1'b0;
                head             <= head + 1'b1;
            end
            case ({alloc_ok, commit_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through busy/ready.
    always_ff @(posedge clk1) begin
        if (!flush && cdb_ok) val[cdb_tag] <= cdb_value;
    end

    always_comb begin
        lk1_ready = ent[lk1_tag].busy && ent[lk1_tag].ready;
        lk1_value = val[lk1_tag];
        lk2_ready = ent[lk2_tag].busy && ent[lk2_tag].ready;
        lk2_value = val[lk2_tag];
        if (cdb_valid && cdb_tag == lk1_tag) begin
            lk1_ready = 1'b1;
            lk1_value = cdb_value;
        end
        if (cdb_valid && cdb_tag == lk2_tag) begin
            lk2_ready = 1'b1;
            lk2_value = cdb_value;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected commits go to a queue, a negedge monitor
// pops and compares them; occupancy/lookup/reset values are checked inline.
module tb_rob_commit;
    import tomasulo_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [3:0]  alloc_func, alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic [2:0]  lk1_tag, lk2_tag;
    logic        lk1_ready, lk2_ready;
    logic [15:0] lk1_value, lk2_value;
    logic        flush;
    logic        commit_valid;
    logic [2:0]  commit_tag;
    logic [3:0]  commit_rd, commit_func;
    logic [15:0] commit_value;
    logic        full, empty;
    logic [3:0]  count;

    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  rd;
        logic [3:0]  func;
        logic [15:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    rob_commit #(.ROB_DEPTH(8), .DATA_W(16)) dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .lk1_tag(lk1_tag), .lk2_tag(lk2_tag),
        .lk1_ready(lk1_ready), .lk2_ready(lk2_ready),
        .lk1_value(lk1_value), .lk2_value(lk2_value),
        .flush(flush),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_func(commit_func), .commit_value(commit_value),
        .full(full), .empty(empty), .count(count)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic push(input logic [2:0] t, input logic [3:0] rd, input logic [3:0] fn,
                        input logic [15:0] v);
        exp_t e;
        e.tag = t; e.rd = rd; e.func = fn; e.value = v;
        sb.push_back(e);
    endtask

    // One clock with the given inputs applied across the edge; strobes drop afterwards.
    task automatic cyc(input logic av, input logic [3:0] fn, input logic [3:0] rd,
                       input logic cv, input logic [2:0] ct, input logic [15:0] cval,
                       input logic fl);
        alloc_valid = av; alloc_func = fn; alloc_rd = rd;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval; flush = fl;
        @(posedge clk1);
        #1;
        alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 4'h0, 0, 3'd0, 16'h0, 0);
    endtask

    always @(negedge clk1) begin
        if (!rst && commit_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_commit: got tag %0d expected no commit at %0t",
                         commit_tag, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("commit_tag",   32'(commit_tag),   32'(e.tag));
                check("commit_rd",    32'(commit_rd),    32'(e.rd));
                check("commit_func",  32'(commit_func),  32'(e.func));
                check("commit_value", 32'(commit_value), 32'(e.value));
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        lk1_tag = '0; lk2_tag = '0;
        #3;
        check("rst_count",       32'(count),        32'd0);
        check("rst_empty",       32'(empty),        32'd1);
        check("rst_full",        32'(full),         32'd0);
        check("rst_alloc_ready", 32'(alloc_ready),  32'd1);
        check("rst_alloc_tag",   32'(alloc_tag),    32'd0);
        check("rst_commit_vld",  32'(commit_valid), 32'd0);
        @(negedge clk1);
        @(negedge clk1);
        rst = 1'b0;

        // in-order commit despite out-of-order completion
        cyc(1, FN_ADD, 4'd1, 0, 3'd0, 16'h0, 0);
        cyc(1, FN_SUB, 4'd2, 0, 3'd0, 16'h0, 0);
        cyc(1, FN_MUL, 4'd3, 0, 3'd0, 16'h0, 0);
        check("t1_count", 32'(count), 32'd3);
        check("t1_tag",   32'(alloc_tag), 32'd3);
        cyc(0, 4'h0, 4'h0, 1, 3'd1, 16'h0022, 0);
        check("t1_no_early_commit", 32'(commit_valid), 32'd0);
        push(3'd0, 4'd1, FN_ADD, 16'h0011);
        push(3'd1, 4'd2, FN_SUB, 16'h0022);
        cyc(0, 4'h0, 4'h0, 1, 3'd0, 16'h0011, 0);
        check("t1_latency", 32'(commit_valid), 32'd0);
        idle(4);
        check("t1_sb_drained", 32'(sb.size()), 32'd0);
        check("t1_count_after", 32'(count), 32'd1);
        cyc(0, 4'h0, 4'h0, 0, 3'd0, 16'h0, 1);
        check("t1_flush_count", 32'(count), 32'd0);

        // fill, overflow, wrap
        for (int i = 0; i < 8; i++) cyc(1, 4'(i), 4'(i), 0, 3'd0, 16'h0, 0);
        check("t2_full",        32'(full),        32'd1);
        check("t2_alloc_ready", 32'(alloc_ready), 32'd0);
        check("t2_count8",      32'(count),       32'd8);
        cyc(1, 4'hF, 4'hF, 0, 3'd0, 16'h0, 0);
        check("t2_ovf_count",   32'(count),       32'd8);
        check("t2_ovf_tag",     32'(alloc_tag),   32'd0);
        push(3'd0, 4'd0, 4'd0, 16'h1000);
        cyc(0, 4'h0, 4'h0, 1, 3'd0, 16'h1000, 0);
        idle(1);
        check("t2_count7",      32'(count),       32'd7);
        check("t2_wrap_tag",    32'(alloc_tag),   32'd0);
        cyc(1, 4'd9, 4'd9, 0, 3'd0, 16'h0, 0);
        check("t2_refill",      32'(count),       32'd8);

        // full with ready head: commit wins, same-edge alloc rejected
        push(3'd1, 4'd1, 4'd1, 16'h2001);
        cyc(0, 4'h0, 4'h0, 1, 3'd1, 16'h2001, 0);
        cyc(1, 4'hE, 4'hE, 0, 3'd0, 16'h0, 0);
        check("t3_count7",     32'(count),        32'd7);
        check("t3_tail_stay",  32'(alloc_tag),    32'd1);
        check("t3_commit_vld", 32'(commit_valid), 32'd1);

        // combinational CDB bypass on lookup, then stored value
        lk1_tag = 3'd3; lk2_tag = 3'd4;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_value = 16'h00AB;
        #1;
        check("t4_byp_ready", 32'(lk1_ready), 32'd1);
        check("t4_byp_value", 32'(lk1_value), 32'h00AB);
        check("t4_lk2_ready", 32'(lk2_ready), 32'd0);
        @(posedge clk1);
        #1;
        cdb_valid = 1'b0;
        #1;
        check("t4_stored_ready", 32'(lk1_ready), 32'd1);
        check("t4_stored_value", 32'(lk1_value), 32'h00AB);
        idle(2);

        // flush beats a ready head, alloc and cdb in the same cycle
        cyc(0, 4'h0, 4'h0, 0, 3'd0, 16'h0, 1);
        for (int i = 0; i < 5; i++) cyc(1, FN_DIV, 4'(i + 4), 0, 3'd0, 16'h0, 0);
        check("t5_count5", 32'(count), 32'd5);
        cyc(0, 4'h0, 4'h0, 1, 3'd0, 16'h0BAD, 0);
        cyc(1, FN_ADD, 4'd7, 1, 3'd1, 16'h0BEE, 1);
        check("t5_count0",     32'(count),        32'd0);
        check("t5_empty",      32'(empty),        32'd1);
        check("t5_commit_vld", 32'(commit_valid), 32'd0);
        check("t5_tag0",       32'(alloc_tag),    32'd0);
        lk1_tag = 3'd1;
        #1;
        check("t5_lk_cleared", 32'(lk1_ready), 32'd0);

        // cdb to the tail on the allocating edge is dropped
        cyc(1, FN_ADD, 4'd1, 0, 3'd0, 16'h0, 0);
        cyc(1, FN_SUB, 4'd2, 1, 3'd1, 16'h5555, 0);
        #1;
        check("t6_cdb_tail_drop", 32'(lk1_ready), 32'd0);
        check("t6_count2",        32'(count),     32'd2);

        // asynchronous reset mid-stream
        cyc(1, FN_MUL, 4'd3, 0, 3'd0, 16'h0, 0);
        cyc(1, FN_MUL, 4'd4, 0, 3'd0, 16'h0, 0);
        check("t7_count4", 32'(count), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("t7_rst_count",  32'(count),        32'd0);
        check("t7_rst_empty",  32'(empty),        32'd1);
        check("t7_rst_tag",    32'(alloc_tag),    32'd0);
        check("t7_rst_cvld",   32'(commit_valid), 32'd0);
        check("t7_rst_ctag",   32'(commit_tag),   32'd0);
        check("t7_rst_cval",   32'(commit_value), 32'd0);
        check("t7_rst_crd",    32'(commit_rd),    32'd0);
        @(negedge clk1);
        rst = 1'b0;
        cyc(1, FN_ADD, 4'd5, 0, 3'd0, 16'h0, 0);
        check("t7_post_count", 32'(count),     32'd1);
        check("t7_post_tag",   32'(alloc_tag), 32'd1);

        idle(3);
        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
